// File: rtl/edit_field_controller.sv
`default_nettype none
// ============================================================================
// Module      : edit_field_controller
// Description : Edit sequencer for the six RTC time/date fields. Holds a BCD
//               shadow copy of each field, moves a cursor with key pulses,
//               applies BCD increment/decrement with per-field wrap and, when
//               edit mode ends, writes back only the modified fields over a
//               req/ack handshake with an acknowledge timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module edit_field_controller #(
    parameter logic [7:0] ADDR_BASE   = 8'h21,
    parameter int         ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        edit_en,
    input  logic        sumar,
    input  logic        restar,
    input  logic        izquierda,
    input  logic        derecha,
    input  logic        live_load,
    input  logic [2:0]  live_sel,
    input  logic [7:0]  live_data,
    input  logic        wr_ack,
    output logic [2:0]  cursor,
    output logic [47:0] field_bcd,
    output logic [5:0]  dirty,
    output logic        editing,
    output logic        busy,
    output logic        wr_req,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        err
);

    // The counter only has to reach ACK_TIMEOUT-1, so clog2(ACK_TIMEOUT) bits
    // are enough.
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [2:0] LAST_FIELD = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EDIT   = 2'd1,
        S_COMMIT = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    state_t           state_q;
    logic [2:0]       cursor_q;
    logic [7:0]       field_q [0:5];
    logic [5:0]       dirty_q;
    logic             editing_q;
    logic             busy_q;
    logic             wr_req_q;
    logic [7:0]       wr_addr_q;
    logic [7:0]       wr_data_q;
    logic             err_q;
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] tmo_q;

    // Candidate next values for the field under the cursor.
    logic [7:0] cur_val;
    logic [7:0] cur_min;
    logic [7:0] cur_max;
    logic [7:0] inc_d;
    logic [7:0] dec_d;

    // Lowest legal BCD value of a field (day and month start at 1).
    function automatic logic [7:0] field_min(input logic [2:0] i);
        case (i)
            3'd3, 3'd4: field_min = 8'h01;
            default:    field_min = 8'h00;
        endcase
    endfunction

    // Highest legal BCD value of a field; day is fixed at 31 regardless of month.
    function automatic logic [7:0] field_max(input logic [2:0] i);
        case (i)
            3'd0, 3'd1: field_max = 8'h59;
            3'd2:       field_max = 8'h23;
            3'd3:       field_max = 8'h31;
            3'd4:       field_max = 8'h12;
            default:    field_max = 8'h99;
        endcase
    endfunction

    // BCD increment/decrement with wrap for the field under the cursor.
    always_comb begin
        cur_val = field_q[cursor_q];
        cur_min = field_min(cursor_q);
        cur_max = field_max(cursor_q);

        if (cur_val == cur_max) begin
            inc_d = cur_min;
        end else if (cur_val[3:0] >= 4'd9) begin
            inc_d = {cur_val[7:4] + 4'd1, 4'd0};
        end else begin
            inc_d = {cur_val[7:4], cur_val[3:0] + 4'd1};
        end

        if (cur_val == cur_min) begin
            dec_d = cur_max;
        end else if (cur_val[3:0] == 4'd0) begin
            dec_d = {cur_val[7:4] - 4'd1, 4'd9};
        end else begin
            dec_d = {cur_val[7:4], cur_val[3:0] - 4'd1};
        end
    end

    // Main sequencer: idle live loads, key editing, commit scan and ack wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cursor_q   <= 3'd0;
            field_q[0] <= 8'h00;
            field_q[1] <= 8'h00;
            field_q[2] <= 8'h00;
            field_q[3] <= 8'h01;
            field_q[4] <= 8'h01;
            field_q[5] <= 8'h00;
            dirty_q    <= 6'd0;
            editing_q  <= 1'b0;
            busy_q     <= 1'b0;
            wr_req_q   <= 1'b0;
            wr_addr_q  <= 8'h00;
            wr_data_q  <= 8'h00;
            err_q      <= 1'b0;
            idx_q      <= 3'd0;
            tmo_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (live_load && (live_sel <= LAST_FIELD)) begin
                        field_q[live_sel] <= live_data;
                    end
                    if (edit_en) begin
                        state_q   <= S_EDIT;
                        cursor_q  <= 3'd0;
                        editing_q <= 1'b1;
                    end
                end

                S_EDIT: begin
                    // One key action per cycle, highest priority first.
                    if (sumar) begin
                        field_q[cursor_q] <= inc_d;
                        dirty_q[cursor_q] <= 1'b1;
                    end else if (restar) begin
                        field_q[cursor_q] <= dec_d;
                        dirty_q[cursor_q] <= 1'b1;
                    end else if (izquierda) begin
                        cursor_q <= (cursor_q == 3'd0) ? LAST_FIELD : cursor_q - 3'd1;
                    end else if (derecha) begin
                        cursor_q <= (cursor_q == LAST_FIELD) ? 3'd0 : cursor_q + 3'd1;
                    end
                    if (!edit_en) begin
                        state_q   <= S_COMMIT;
                        idx_q     <= 3'd0;
                        editing_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end

                S_COMMIT: begin
                    if (dirty_q[idx_q]) begin
                        wr_req_q  <= 1'b1;
                        wr_addr_q <= ADDR_BASE + {5'd0, idx_q};
                        wr_data_q <= field_q[idx_q];
                        tmo_q     <= '0;
                        state_q   <= S_WAIT;
                    end else if (idx_q == LAST_FIELD) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end

                S_WAIT: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (wr_ack || (tmo_q == TMO_LAST)) begin
                        wr_req_q <= 1'b0;
                        if (wr_ack) begin
                            dirty_q[idx_q] <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (idx_q == LAST_FIELD) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            state_q <= S_COMMIT;
                        end
                    end else begin
                        tmo_q <= tmo_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_pack
            assign field_bcd[8*gi +: 8] = field_q[gi];
        end
    endgenerate

    assign cursor  = cursor_q;
    assign dirty   = dirty_q;
    assign editing = editing_q;
    assign busy    = busy_q;
    assign wr_req  = wr_req_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_edit_field_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_edit_field_controller
// Description : Directed bench for edit_field_controller. Expected RTC writes
//               are queued by the stimulus and checked by an independent
//               monitor; field, cursor and flag values are checked inline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edit_field_controller;

    localparam int K_SUM = 0;
    localparam int K_RES = 1;
    localparam int K_IZQ = 2;
    localparam int K_DER = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        edit_en = 1'b0;
    logic        sumar = 1'b0;
    logic        restar = 1'b0;
    logic        izquierda = 1'b0;
    logic        derecha = 1'b0;
    logic        live_load = 1'b0;
    logic [2:0]  live_sel = 3'd0;
    logic [7:0]  live_data = 8'h00;
    logic        wr_ack = 1'b0;
    logic [2:0]  cursor;
    logic [47:0] field_bcd;
    logic [5:0]  dirty;
    logic        editing;
    logic        busy;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        err;

    int errors = 0;
    int checks = 0;
    bit ack_en = 1'b1;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;
    wr_t exp_q[$];

    edit_field_controller #(
        .ADDR_BASE   (8'h21),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .edit_en   (edit_en),
        .sumar     (sumar),
        .restar    (restar),
        .izquierda (izquierda),
        .derecha   (derecha),
        .live_load (live_load),
        .live_sel  (live_sel),
        .live_data (live_data),
        .wr_ack    (wr_ack),
        .cursor    (cursor),
        .field_bcd (field_bcd),
        .dirty     (dirty),
        .editing   (editing),
        .busy      (busy),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic press(input int k);
        case (k)
            K_SUM:   sumar = 1'b1;
            K_RES:   restar = 1'b1;
            K_IZQ:   izquierda = 1'b1;
            default: derecha = 1'b1;
        endcase
        tick();
        sumar = 1'b0;
        restar = 1'b0;
        izquierda = 1'b0;
        derecha = 1'b0;
    endtask

    task automatic load(input logic [2:0] sel, input logic [7:0] data);
        live_load = 1'b1;
        live_sel  = sel;
        live_data = data;
        tick();
        live_load = 1'b0;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(nm, {47'd0, busy}, 48'd0);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        while (!wr_req && n < 100) begin
            tick();
            n++;
        end
        chk(nm, {47'd0, wr_req}, 48'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cursor"}, {45'd0, cursor}, 48'd0);
        chk({tag, "_fields"}, field_bcd, {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00});
        chk({tag, "_dirty"}, {42'd0, dirty}, 48'd0);
        chk({tag, "_flags"}, {44'd0, editing, busy, wr_req, err}, 48'd0);
        chk({tag, "_wr_bus"}, {32'd0, wr_addr, wr_data}, 48'd0);
    endtask

    // Acknowledge responder: ack one cycle wide, two cycles after wr_req rises.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_en && wr_req && !reset) begin
                tick();
                wr_ack = 1'b1;
                tick();
                wr_ack = 0;
            end
        end
    end

    // Write monitor: pops the expected write on each request and checks the
    // bus stays on that value while the request is held.
    initial begin
        logic prev = 1'b0;
        wr_t  cur;
        cur.a = 8'h00;
        cur.d = 8'h00;
        forever begin
            @(negedge clk);
            if (wr_req && !prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", wr_addr, wr_data);
                end else begin
                    cur = exp_q.pop_front();
                    chk("wr_addr", {40'd0, wr_addr}, {40'd0, cur.a});
                    chk("wr_data", {40'd0, wr_data}, {40'd0, cur.d});
                end
            end else if (wr_req && prev) begin
                chk("wr_hold", {32'd0, wr_addr, wr_data}, {32'd0, cur.a, cur.d});
            end
            prev = wr_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state.
        tick();
        tick();
        reset = 1'b0;
        chk_reset_state("reset");

        // Three increments on seconds.
        edit_en = 1'b1;
        tick();
        chk("enter_edit", {44'd0, editing, busy, cursor[1:0]}, {44'd0, 4'b1000});
        press(K_SUM);
        press(K_SUM);
        press(K_SUM);
        chk("sec_x3", {40'd0, field_bcd[7:0]}, {40'd0, 8'h03});
        chk("dirty_sec", {42'd0, dirty}, {42'd0, 6'b000001});
        push_wr(8'h21, 8'h03);
        edit_en = 1'b0;
        tick();
        chk("commit_busy", {46'd0, editing, busy}, {46'd0, 2'b01});
        wait_idle("commit1_done");
        chk("commit1_dirty", {42'd0, dirty}, 48'd0);

        // Live loads, ignored out-of-range select, wraps and cursor moves.
        load(3'd1, 8'h59);
        load(3'd3, 8'h31);
        load(3'd6, 8'h77);
        chk("live_load", field_bcd, {8'h00, 8'h01, 8'h31, 8'h00, 8'h59, 8'h03});
        edit_en = 1'b1;
        tick();
        press(K_DER);
        chk("cursor_1", {45'd0, cursor}, 48'd1);
        press(K_SUM);
        chk("min_wrap_up", {40'd0, field_bcd[15:8]}, {40'd0, 8'h00});
        press(K_RES);
        chk("min_wrap_dn", {40'd0, field_bcd[15:8]}, {40'd0, 8'h59});
        press(K_DER);
        press(K_DER);
        press(K_DER);
        press(K_RES);
        chk("month_wrap_dn", {40'd0, field_bcd[39:32]}, {40'd0, 8'h12});
        press(K_IZQ);
        press(K_SUM);
        chk("day_wrap_up", {40'd0, field_bcd[31:24]}, {40'd0, 8'h01});
        press(K_IZQ);
        press(K_IZQ);
        press(K_IZQ);
        chk("cursor_0", {45'd0, cursor}, 48'd0);
        press(K_IZQ);
        chk("cursor_wrap_left", {45'd0, cursor}, 48'd5);
        press(K_DER);
        chk("cursor_wrap_right", {45'd0, cursor}, 48'd0);
        sumar = 1'b1;
        derecha = 1'b1;
        tick();
        sumar = 1'b0;
        derecha = 1'b0;
        chk("prio_inc", {40'd0, field_bcd[7:0]}, {40'd0, 8'h04});
        chk("prio_cursor", {45'd0, cursor}, 48'd0);
        press(K_DER);
        chk("dirty_multi", {42'd0, dirty}, {42'd0, 6'b011011});
        push_wr(8'h21, 8'h04);
        push_wr(8'h22, 8'h59);
        push_wr(8'h24, 8'h01);
        push_wr(8'h25, 8'h12);
        edit_en = 1'b0;
        tick();
        wait_idle("commit2_done");
        chk("commit2_dirty", {42'd0, dirty}, 48'd0);

        // Fields 2 and 5 with BCD carry/borrow, then a two-write commit.
        load(3'd2, 8'h19);
        edit_en = 1'b1;
        tick();
        chk("reenter_cursor", {45'd0, cursor}, 48'd0);
        press(K_DER);
        press(K_DER);
        press(K_SUM);
        chk("bcd_carry", {40'd0, field_bcd[23:16]}, {40'd0, 8'h20});
        press(K_RES);
        chk("bcd_borrow", {40'd0, field_bcd[23:16]}, {40'd0, 8'h19});
        press(K_DER);
        press(K_DER);
        press(K_DER);
        press(K_RES);
        chk("year_wrap_dn", {40'd0, field_bcd[47:40]}, {40'd0, 8'h99});
        press(K_RES);
        load(3'd5, 8'h42);
        chk("edit_live_ignored", {40'd0, field_bcd[47:40]}, {40'd0, 8'h98});
        chk("dirty_2_5", {42'd0, dirty}, {42'd0, 6'b100100});
        push_wr(8'h23, 8'h19);
        push_wr(8'h26, 8'h98);
        edit_en = 1'b0;
        tick();
        wait_idle("commit3_done");
        chk("commit3_dirty", {42'd0, dirty}, 48'd0);
        chk("commit3_err", {47'd0, err}, 48'd0);
        chk("commit3_queue", 48'(exp_q.size()), 48'd0);

        // Never acknowledge: timeout, sticky err, next field attempted.
        ack_en = 1'b0;
        edit_en = 1'b1;
        tick();
        press(K_SUM);
        press(K_DER);
        press(K_SUM);
        push_wr(8'h21, 8'h05);
        push_wr(8'h22, 8'h00);
        edit_en = 1'b0;
        tick();
        wait_req("tmo_req1");
        n = 0;
        while (wr_req && n < 50) begin
            tick();
            n++;
        end
        chk("tmo_req_len", 48'(n), 48'd8);
        chk("tmo_err", {47'd0, err}, 48'd1);
        chk("tmo_dirty_kept", {42'd0, dirty}, {42'd0, 6'b000011});
        wait_req("tmo_req2");

        // Reset while waiting on the second request.
        tick();
        reset = 1'b1;
        tick();
        chk_reset_state("wait_reset");
        reset = 1'b0;
        tick();
        chk("final_queue", 48'(exp_q.size()), 48'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
